// File: rtl/framebuffer_pkg.sv
// Shared constants for the framebuffer arbiter: geometry defaults, pixel width and the
// arbiter FSM state encodings.
package framebuffer_pkg;

  localparam int unsigned FB_ADDRESS_WIDTH = 19;
  localparam int unsigned FB_FRAME_PIXELS  = 307200;
  localparam int unsigned PIXEL_WIDTH      = 12;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_READ_SETUP   = 3'd1;
  localparam logic [2:0] ST_READ_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WRITE_SETUP  = 3'd3;
  localparam logic [2:0] ST_WRITE_STROBE = 3'd4;

endpackage

// File: rtl/pixel_write_fifo.sv
// Pending-write queue: each entry pairs a framebuffer address with its 12-bit pixel.
// DEPTH must be a power of two (two or more).
module pixel_write_fifo #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ADDRESS_WIDTH = 19,
  parameter int unsigned DATA_WIDTH    = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ADDRESS_WIDTH-1:0] push_address,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [ADDRESS_WIDTH-1:0] head_address,
  output logic [DATA_WIDTH-1:0]    head_data,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

  logic [ADDRESS_WIDTH-1:0] address_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem    [DEPTH];
  logic [PTR_WIDTH-1:0]     write_ptr_q;
  logic [PTR_WIDTH-1:0]     read_ptr_q;
  logic [PTR_WIDTH:0]       count_q;
  logic                     push_ok;
  logic                     pop_ok;

  // Count only reaches DEPTH (a power of two) when full, so its MSB is the full flag.
  assign full         = count_q[PTR_WIDTH];
  assign empty        = (count_q == '0);
  assign push_ok      = push && !full;
  assign pop_ok       = pop && !empty;
  assign head_address = address_mem[read_ptr_q];
  assign head_data    = data_mem[read_ptr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      write_ptr_q <= '0;
      read_ptr_q  <= '0;
      count_q     <= '0;
    end else begin
      if (push_ok) write_ptr_q <= write_ptr_q + 1'b1;
      if (pop_ok)  read_ptr_q  <= read_ptr_q + 1'b1;
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      address_mem[write_ptr_q] <= push_address;
      data_mem[write_ptr_q]    <= push_data;
    end
  end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Arbitrates one asynchronous SRAM between queued pixel writes and single display reads.
// Reads always win; every SRAM access is a two-cycle setup/strobe (or setup/capture) pair.
module framebuffer_arbiter
  import framebuffer_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = FB_ADDRESS_WIDTH,
  parameter int unsigned FRAME_PIXELS  = FB_FRAME_PIXELS,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     system_clock,
  input  logic                     reset,
  input  logic                     pixel_write_valid,
  input  logic [PIXEL_WIDTH-1:0]   pixel_write_data,
  output logic                     pixel_write_ready,
  input  logic                     address_load,
  input  logic [ADDRESS_WIDTH-1:0] address_value,
  input  logic                     display_read_request,
  input  logic [ADDRESS_WIDTH-1:0] display_read_address,
  output logic [PIXEL_WIDTH-1:0]   display_read_data,
  output logic                     display_read_valid,
  output logic [ADDRESS_WIDTH-1:0] sram_address,
  output logic [PIXEL_WIDTH-1:0]   sram_data_out,
  input  logic [PIXEL_WIDTH-1:0]   sram_data_in,
  output logic                     sram_write_enable,
  output logic                     sram_output_enable,
  output logic                     write_overflow
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_PIXEL = ADDRESS_WIDTH'(FRAME_PIXELS - 1);

  function automatic logic [ADDRESS_WIDTH-1:0] advance(input logic [ADDRESS_WIDTH-1:0] addr);
    if (addr >= LAST_PIXEL) return '0;
    return addr + 1'b1;
  endfunction

  logic [2:0]               state_q;
  logic [2:0]               state_d;
  logic                     read_pending_q;
  logic [ADDRESS_WIDTH-1:0] read_address_q;
  logic [ADDRESS_WIDTH-1:0] cursor_q;
  logic [ADDRESS_WIDTH-1:0] cursor_d;
  logic [ADDRESS_WIDTH-1:0] push_address;
  logic [ADDRESS_WIDTH-1:0] head_address;
  logic [PIXEL_WIDTH-1:0]   head_data;
  logic [ADDRESS_WIDTH-1:0] read_target;
  logic                     read_go;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;

  pixel_write_fifo #(
    .DEPTH         (FIFO_DEPTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (PIXEL_WIDTH)
  ) u_fifo (
    .clock        (system_clock),
    .reset        (reset),
    .push         (fifo_push),
    .push_address (push_address),
    .push_data    (pixel_write_data),
    .pop          (fifo_pop),
    .head_address (head_address),
    .head_data    (head_data),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  assign pixel_write_ready = !fifo_full;
  // The entry stays queued through WRITE_SETUP, so a pixel arriving then still sees full.
  assign fifo_pop          = (state_q == ST_WRITE_SETUP);
  // A request arriving in a decision cycle is served without waiting to be latched.
  assign read_go           = read_pending_q || display_read_request;
  assign read_target       = read_pending_q ? read_address_q : display_read_address;

  always_comb begin
    push_address = address_load ? address_value : cursor_q;
    fifo_push    = pixel_write_valid && !fifo_full;
    cursor_d     = cursor_q;
    if (fifo_push) begin
      cursor_d = advance(push_address);
    end else if (address_load) begin
      cursor_d = address_value;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READ_SETUP:  state_d = ST_READ_CAPTURE;
      ST_WRITE_SETUP: state_d = ST_WRITE_STROBE;
      default: begin
        if (read_go) begin
          state_d = ST_READ_SETUP;
        end else if (!fifo_empty) begin
          state_d = ST_WRITE_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      read_pending_q     <= 1'b0;
      read_address_q     <= '0;
      cursor_q           <= '0;
      write_overflow     <= 1'b0;
      sram_address       <= '0;
      sram_data_out      <= '0;
      sram_write_enable  <= 1'b0;
      sram_output_enable <= 1'b0;
      display_read_data  <= '0;
      display_read_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      if (pixel_write_valid && fifo_full) write_overflow <= 1'b1;

      if (state_d == ST_READ_SETUP) begin
        read_pending_q <= 1'b0;
      end else if (display_read_request) begin
        read_pending_q <= 1'b1;
      end
      if (display_read_request) read_address_q <= display_read_address;

      sram_write_enable  <= (state_d == ST_WRITE_STROBE);
      sram_output_enable <= (state_d == ST_READ_SETUP) || (state_d == ST_READ_CAPTURE);
      if (state_d == ST_READ_SETUP) begin
        sram_address <= read_target;
      end else if (state_d == ST_WRITE_SETUP) begin
        sram_address  <= head_address;
        sram_data_out <= head_data;
      end

      display_read_valid <= (state_q == ST_READ_CAPTURE);
      if (state_q == ST_READ_CAPTURE) display_read_data <= sram_data_in;
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter: writes, cursor wrap, read latency, overflow and
// reset during an access.
module tb_framebuffer_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_write_valid;
  logic [11:0] pixel_write_data;
  logic        pixel_write_ready;
  logic        address_load;
  logic [18:0] address_value;
  logic        display_read_request;
  logic [18:0] display_read_address;
  logic [11:0] display_read_data;
  logic        display_read_valid;
  logic [18:0] sram_address;
  logic [11:0] sram_data_out;
  logic [11:0] sram_data_in;
  logic        sram_write_enable;
  logic        sram_output_enable;
  logic        write_overflow;

  always #5 clk = ~clk;

  framebuffer_arbiter #(
    .ADDRESS_WIDTH (19),
    .FRAME_PIXELS  (307200),
    .FIFO_DEPTH    (4)
  ) dut (
    .system_clock         (clk),
    .reset                (reset),
    .pixel_write_valid    (pixel_write_valid),
    .pixel_write_data     (pixel_write_data),
    .pixel_write_ready    (pixel_write_ready),
    .address_load         (address_load),
    .address_value        (address_value),
    .display_read_request (display_read_request),
    .display_read_address (display_read_address),
    .display_read_data    (display_read_data),
    .display_read_valid   (display_read_valid),
    .sram_address         (sram_address),
    .sram_data_out        (sram_data_out),
    .sram_data_in         (sram_data_in),
    .sram_write_enable    (sram_write_enable),
    .sram_output_enable   (sram_output_enable),
    .write_overflow       (write_overflow)
  );

  int checks = 0;
  int errors = 0;
  int valid_count = 0;
  int overlap_count = 0;
  int double_strobe = 0;
  logic prev_we = 1'b0;
  logic [18:0] wr_addr[$];
  logic [11:0] wr_data[$];

  // SRAM-side observer: logs every write strobe and flags illegal strobe patterns.
  always @(negedge clk) begin
    if (sram_write_enable) begin
      wr_addr.push_back(sram_address);
      wr_data.push_back(sram_data_out);
    end
    if (sram_write_enable && prev_we) double_strobe++;
    if (sram_write_enable && sram_output_enable) overlap_count++;
    if (display_read_valid) valid_count++;
    prev_we = sram_write_enable;
  end

  function automatic logic [18:0] wa(input int i);
    if (i < wr_addr.size()) return wr_addr[i];
    return 'x;
  endfunction

  function automatic logic [11:0] wd(input int i);
    if (i < wr_data.size()) return wr_data[i];
    return 'x;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pixel_write_valid = 1'b1;
    pixel_write_data = 12'hFFF;
    display_read_request = 1'b1;
    display_read_address = 19'd7;
    step(3);
    pixel_write_valid = 1'b0;
    display_read_request = 1'b0;
    checks++; if (pixel_write_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", pixel_write_ready); end
    checks++; if (display_read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", display_read_valid); end
    checks++; if (display_read_data !== 12'h000) begin errors++; $display("FAIL reset_rdata: got %h want 000", display_read_data); end
    checks++; if (sram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", sram_write_enable); end
    checks++; if (sram_output_enable !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", sram_output_enable); end
    checks++; if (sram_address !== 19'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", sram_address); end
    checks++; if (sram_data_out !== 12'h000) begin errors++; $display("FAIL reset_wdata: got %h want 000", sram_data_out); end
    checks++; if (write_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", write_overflow); end
    reset = 1'b0;
    step(2);
    checks++; if (sram_output_enable !== 1'b0) begin errors++; $display("FAIL reset_idle_oe: got %b want 0", sram_output_enable); end
  endtask

  task automatic test_basic_write();
    clear_log();
    pixel_write_valid = 1'b1;
    pixel_write_data = 12'hABC;
    step();
    pixel_write_data = 12'h123;
    step();
    pixel_write_valid = 1'b0;
    checks++; if (sram_address !== 19'd0 || sram_data_out !== 12'hABC || sram_write_enable !== 1'b0) begin
      errors++; $display("FAIL write_setup: got addr %0d data %h we %b want 0 abc 0", sram_address, sram_data_out, sram_write_enable); end
    step();
    checks++; if (sram_write_enable !== 1'b1 || sram_address !== 19'd0) begin
      errors++; $display("FAIL write_strobe: got we %b addr %0d want 1 0", sram_write_enable, sram_address); end
    step(8);
    checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d want 2", wr_addr.size()); end
    checks++; if (wa(0) !== 19'd0 || wd(0) !== 12'hABC) begin errors++; $display("FAIL basic_w0: got %0d/%h want 0/abc", wa(0), wd(0)); end
    checks++; if (wa(1) !== 19'd1 || wd(1) !== 12'h123) begin errors++; $display("FAIL basic_w1: got %0d/%h want 1/123", wa(1), wd(1)); end
    checks++; if (double_strobe !== 0) begin errors++; $display("FAIL basic_strobe_len: got %0d long strobes want 0", double_strobe); end
  endtask

  task automatic test_wrap();
    clear_log();
    address_load = 1'b1;
    address_value = 19'd307199;
    pixel_write_valid = 1'b1;
    pixel_write_data = 12'h001;
    step();
    address_load = 1'b0;
    pixel_write_data = 12'h002;
    step();
    pixel_write_valid = 1'b0;
    step(10);
    checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL wrap_count: got %0d want 2", wr_addr.size()); end
    checks++; if (wa(0) !== 19'd307199 || wd(0) !== 12'h001) begin errors++; $display("FAIL wrap_w0: got %0d/%h want 307199/001", wa(0), wd(0)); end
    checks++; if (wa(1) !== 19'd0 || wd(1) !== 12'h002) begin errors++; $display("FAIL wrap_w1: got %0d/%h want 0/002", wa(1), wd(1)); end
  endtask

  task automatic test_read_idle();
    int v0;
    v0 = valid_count;
    sram_data_in = 12'hF0F;
    display_read_request = 1'b1;
    display_read_address = 19'd5;
    step();
    display_read_request = 1'b0;
    checks++; if (sram_address !== 19'd5 || sram_output_enable !== 1'b1 || sram_write_enable !== 1'b0) begin
      errors++; $display("FAIL read_setup: got addr %0d oe %b we %b want 5 1 0", sram_address, sram_output_enable, sram_write_enable); end
    step();
    checks++; if (display_read_valid !== 1'b0) begin errors++; $display("FAIL read_early: got %b want 0", display_read_valid); end
    step();
    checks++; if (display_read_valid !== 1'b1 || display_read_data !== 12'hF0F) begin
      errors++; $display("FAIL read_idle_lat3: got valid %b data %h want 1 f0f", display_read_valid, display_read_data); end
    step();
    checks++; if (display_read_valid !== 1'b0) begin errors++; $display("FAIL read_pulse: got %b want 0", display_read_valid); end
    checks++; if (valid_count - v0 !== 1) begin errors++; $display("FAIL read_pulse_count: got %0d want 1", valid_count - v0); end
  endtask

  task automatic test_read_during_write();
    clear_log();
    sram_data_in = 12'h5A5;
    address_load = 1'b1;
    address_value = 19'd50;
    pixel_write_valid = 1'b1;
    pixel_write_data = 12'h456;
    step();
    address_load = 1'b0;
    pixel_write_valid = 1'b0;
    step();
    checks++; if (sram_address !== 19'd50 || sram_data_out !== 12'h456 || sram_write_enable !== 1'b0) begin
      errors++; $display("FAIL rdw_setup: got addr %0d data %h we %b want 50 456 0", sram_address, sram_data_out, sram_write_enable); end
    display_read_request = 1'b1;
    display_read_address = 19'd9;
    step();
    display_read_request = 1'b0;
    checks++; if (sram_write_enable !== 1'b1) begin errors++; $display("FAIL rdw_strobe: got %b want 1", sram_write_enable); end
    step();
    checks++; if (sram_address !== 19'd9 || sram_output_enable !== 1'b1) begin
      errors++; $display("FAIL rdw_read_setup: got addr %0d oe %b want 9 1", sram_address, sram_output_enable); end
    step();
    checks++; if (display_read_valid !== 1'b0) begin errors++; $display("FAIL rdw_early: got %b want 0", display_read_valid); end
    step();
    checks++; if (display_read_valid !== 1'b1 || display_read_data !== 12'h5A5) begin
      errors++; $display("FAIL rdw_lat4: got valid %b data %h want 1 5a5", display_read_valid, display_read_data); end
    checks++; if (wr_addr.size() !== 1 || wa(0) !== 19'd50 || wd(0) !== 12'h456) begin
      errors++; $display("FAIL rdw_write_first: got n=%0d %0d/%h want 1 50/456", wr_addr.size(), wa(0), wd(0)); end
    step(4);
  endtask

  task automatic test_back_to_back();
    clear_log();
    sram_data_in = 12'h777;
    for (int t = 0; t < 24; t++) begin
      if (t == 5) begin
        checks++; if (pixel_write_ready !== 1'b1 || write_overflow !== 1'b0) begin
          errors++; $display("FAIL b2b_before_full: got ready %b ovf %b want 1 0", pixel_write_ready, write_overflow); end
      end
      if (t == 6) begin
        checks++; if (pixel_write_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", pixel_write_ready); end
      end
      if (t == 7) begin
        checks++; if (write_overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow: got %b want 1", write_overflow); end
      end
      display_read_request = (t == 0) || (t < 16 && display_read_valid);
      display_read_address = 19'(30 + t);
      pixel_write_valid = (t >= 2 && t <= 6);
      pixel_write_data = 12'(12'h100 + t);
      address_load = (t == 2);
      address_value = 19'd100;
      step();
    end
    display_read_request = 1'b0;
    pixel_write_valid = 1'b0;
    address_load = 1'b0;
    step(30);
    checks++; if (wr_addr.size() !== 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wa(i) !== 19'(100 + i) || wd(i) !== 12'(12'h102 + i)) begin
        errors++; $display("FAIL b2b_order[%0d]: got %0d/%h want %0d/%h", i, wa(i), wd(i), 100 + i, 12'h102 + i); end
    end
    checks++; if (write_overflow !== 1'b1) begin errors++; $display("FAIL b2b_sticky: got %b want 1", write_overflow); end
    checks++; if (overlap_count !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles want 0", overlap_count); end
    checks++; if (double_strobe !== 0) begin errors++; $display("FAIL b2b_strobe_len: got %0d want 0", double_strobe); end
  endtask

  task automatic test_reset_mid_write();
    int v0;
    clear_log();
    address_load = 1'b1;
    address_value = 19'd200;
    pixel_write_valid = 1'b1;
    pixel_write_data = 12'hA01;
    step();
    address_load = 1'b0;
    pixel_write_data = 12'hA02;
    step();
    pixel_write_data = 12'hA03;
    step();
    pixel_write_valid = 1'b0;
    checks++; if (sram_write_enable !== 1'b1 || sram_address !== 19'd200) begin
      errors++; $display("FAIL mid_strobe: got we %b addr %0d want 1 200", sram_write_enable, sram_address); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (sram_write_enable !== 1'b0 || sram_output_enable !== 1'b0) begin
      errors++; $display("FAIL mid_reset_strobes: got we %b oe %b want 0 0", sram_write_enable, sram_output_enable); end
    checks++; if (pixel_write_ready !== 1'b1 || write_overflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset_flags: got ready %b ovf %b want 1 0", pixel_write_ready, write_overflow); end
    v0 = valid_count;
    step(12);
    checks++; if (wr_addr.size() !== 1) begin errors++; $display("FAIL mid_reset_writes: got %0d want 1", wr_addr.size()); end
    checks++; if (valid_count !== v0) begin errors++; $display("FAIL mid_reset_valids: got %0d want %0d", valid_count, v0); end
    checks++; if (sram_address !== 19'd0) begin errors++; $display("FAIL mid_reset_addr: got %0d want 0", sram_address); end
  endtask

  initial begin
    reset = 1'b1;
    pixel_write_valid = 1'b0;
    pixel_write_data = '0;
    address_load = 1'b0;
    address_value = '0;
    display_read_request = 1'b0;
    display_read_address = '0;
    sram_data_in = '0;
    test_reset();
    test_basic_write();
    test_wrap();
    test_read_idle();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
